// File: rtl/cnn_layer_sequencer.sv
// Layer/window command generator: walks a stack of conv and average-pool layers and
// issues one window command per handshake to the compute engine.
module cnn_layer_sequencer #(
    parameter int                    NUM_LAYERS = 5,
    parameter logic [NUM_LAYERS-1:0] LAYER_MODE = 5'b01010,
    parameter int                    IMG_SIZE   = 32,
    parameter int                    K          = 5,
    parameter int                    P          = 2,
    parameter int                    MAPW       = 8,
    localparam int                   LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int                   CW         = $clog2(IMG_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [(NUM_LAYERS+1)*MAPW-1:0] layer_maps,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [LW-1:0]                cmd_layer,
    output logic                         cmd_pool,
    output logic [MAPW-1:0]              cmd_out_map,
    output logic [MAPW-1:0]              cmd_in_map,
    output logic [CW-1:0]                cmd_row,
    output logic [CW-1:0]                cmd_col,
    output logic                         cmd_first,
    output logic                         cmd_last,
    output logic                         busy,
    output logic                         finish,
    output logic                         err
);

    // Side lengths must hold IMG_SIZE itself, so one bit wider than a pixel index.
    localparam int SW = $clog2(IMG_SIZE + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ISSUE, DONE} state_e;

    state_e                         state_q, state_d;
    logic [LW-1:0]                  layer_q, layer_d;
    logic [(NUM_LAYERS+1)*MAPW-1:0] maps_q, maps_d;
    logic [SW-1:0]                  side_in_q, side_in_d;
    logic [SW-1:0]                  side_out_q, side_out_d;
    logic                           pool_q, pool_d;
    logic [MAPW-1:0]                maps_in_q, maps_in_d;
    logic [MAPW-1:0]                maps_out_q, maps_out_d;
    logic [MAPW-1:0]                out_map_q, out_map_d;
    logic [MAPW-1:0]                in_map_q, in_map_d;
    logic [SW-1:0]                  row_q, row_d;
    logic [SW-1:0]                  col_q, col_d;
    logic                           err_q, err_d;

    logic            setup_pool;
    logic [MAPW-1:0] setup_in;
    logic [MAPW-1:0] setup_out;
    int              side_calc;
    logic            side_ok;
    logic            last_layer;
    logic            col_last;
    logic            row_last;
    logic            in_last;
    logic            out_last;
    logic            issuing;

    always_comb begin
        setup_pool = LAYER_MODE[layer_q];
        setup_in   = maps_q[int'(layer_q) * MAPW +: MAPW];
        setup_out  = maps_q[(int'(layer_q) + 1) * MAPW +: MAPW];
        if (setup_pool) begin
            side_calc = int'(side_in_q) / P;
            side_ok   = (side_calc != 0);
        end else begin
            side_calc = int'(side_in_q) - K + 1;
            side_ok   = (int'(side_in_q) >= K);
        end
        last_layer = (int'(layer_q) == NUM_LAYERS - 1);
        col_last   = (col_q == side_out_q - SW'(1));
        row_last   = (row_q == side_out_q - SW'(1));
        in_last    = (in_map_q == maps_in_q - MAPW'(1));
        out_last   = (out_map_q == maps_out_q - MAPW'(1));
        issuing    = (state_q == ISSUE);
    end

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        maps_d     = maps_q;
        side_in_d  = side_in_q;
        side_out_d = side_out_q;
        pool_d     = pool_q;
        maps_in_d  = maps_in_q;
        maps_out_d = maps_out_q;
        out_map_d  = out_map_q;
        in_map_d   = in_map_q;
        row_d      = row_q;
        col_d      = col_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    maps_d    = layer_maps;
                    side_in_d = SW'(IMG_SIZE);
                    layer_d   = '0;
                    err_d     = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                // Pool layers walk each map once, so the output-map loop collapses to one pass.
                if (!side_ok || setup_in == '0 || (!setup_pool && setup_out == '0)) begin
                    if (!side_ok) begin
                        err_d = 1'b1;
                    end
                    if (last_layer) begin
                        state_d = DONE;
                    end else begin
                        layer_d = layer_q + LW'(1);
                    end
                end else begin
                    pool_d     = setup_pool;
                    side_out_d = SW'(side_calc);
                    maps_in_d  = setup_in;
                    maps_out_d = setup_pool ? MAPW'(1) : setup_out;
                    out_map_d  = '0;
                    in_map_d   = '0;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    col_d = col_q + SW'(1);
                    if (col_last) begin
                        col_d = '0;
                        row_d = row_q + SW'(1);
                        if (row_last) begin
                            row_d    = '0;
                            in_map_d = in_map_q + MAPW'(1);
                            if (in_last) begin
                                in_map_d  = '0;
                                out_map_d = out_map_q + MAPW'(1);
                                if (out_last) begin
                                    side_in_d = side_out_q;
                                    if (last_layer) begin
                                        state_d = DONE;
                                    end else begin
                                        layer_d = layer_q + LW'(1);
                                        state_d = SETUP;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            layer_q    <= '0;
            maps_q     <= '0;
            side_in_q  <= '0;
            side_out_q <= '0;
            pool_q     <= 1'b0;
            maps_in_q  <= '0;
            maps_out_q <= '0;
            out_map_q  <= '0;
            in_map_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            maps_q     <= maps_d;
            side_in_q  <= side_in_d;
            side_out_q <= side_out_d;
            pool_q     <= pool_d;
            maps_in_q  <= maps_in_d;
            maps_out_q <= maps_out_d;
            out_map_q  <= out_map_d;
            in_map_q   <= in_map_d;
            row_q      <= row_d;
            col_q      <= col_d;
            err_q      <= err_d;
        end
    end

    // Command fields read zero whenever no command is presented.
    always_comb begin
        cmd_valid   = issuing;
        busy        = (state_q == SETUP) || issuing;
        finish      = (state_q == DONE);
        err         = err_q;
        cmd_layer   = issuing ? layer_q : '0;
        cmd_pool    = issuing & pool_q;
        cmd_out_map = issuing ? (pool_q ? in_map_q : out_map_q) : '0;
        cmd_in_map  = issuing ? in_map_q : '0;
        cmd_row     = issuing ? (pool_q ? CW'(int'(row_q) * P) : CW'(row_q)) : '0;
        cmd_col     = issuing ? (pool_q ? CW'(int'(col_q) * P) : CW'(col_q)) : '0;
        cmd_first   = issuing & (pool_q | (in_map_q == '0));
        cmd_last    = issuing & (pool_q | in_last);
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: default 5-layer stack plus a small
// 3-layer instance that exercises the invalid-layer skip and err handling.
module tb_cnn_layer_sequencer;

    typedef struct packed {
        logic [2:0] layer;
        logic       pool;
        logic [7:0] om;
        logic [7:0] im;
        logic [4:0] row;
        logic [4:0] col;
        logic       first;
        logic       last;
    } cmd_t;

    localparam logic [4:0]  DEF_MODE = 5'b01010;
    localparam logic [47:0] DEF_MAPS = {8'd120, 8'd16, 8'd16, 8'd6, 8'd6, 8'd1};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] layer_maps;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_layer;
    logic        cmd_pool;
    logic [7:0]  cmd_out_map;
    logic [7:0]  cmd_in_map;
    logic [4:0]  cmd_row;
    logic [4:0]  cmd_col;
    logic        cmd_first;
    logic        cmd_last;
    logic        busy;
    logic        finish;
    logic        err;

    logic        s_start;
    logic [31:0] s_maps;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [1:0]  s_cmd_layer;
    logic        s_cmd_pool;
    logic [7:0]  s_cmd_out_map;
    logic [7:0]  s_cmd_in_map;
    logic [2:0]  s_cmd_row;
    logic [2:0]  s_cmd_col;
    logic        s_cmd_first;
    logic        s_cmd_last;
    logic        s_busy;
    logic        s_finish;
    logic        s_err;

    cmd_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          finish_cnt = 0;
    int          ready_mode = 0;
    logic        prev_stall = 1'b0;
    logic        expect_fin = 1'b0;
    cmd_t        held;
    int          s_hs = 0;
    int          s_fin = 0;
    logic [23:0] s_first;

    always #5 clk = ~clk;

    cnn_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .layer_maps(layer_maps),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_layer(cmd_layer),
        .cmd_pool(cmd_pool), .cmd_out_map(cmd_out_map), .cmd_in_map(cmd_in_map),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_first(cmd_first),
        .cmd_last(cmd_last), .busy(busy), .finish(finish), .err(err)
    );

    cnn_layer_sequencer #(
        .NUM_LAYERS(3), .LAYER_MODE(3'b010), .IMG_SIZE(8), .K(5), .P(2), .MAPW(8)
    ) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .layer_maps(s_maps),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_layer(s_cmd_layer),
        .cmd_pool(s_cmd_pool), .cmd_out_map(s_cmd_out_map), .cmd_in_map(s_cmd_in_map),
        .cmd_row(s_cmd_row), .cmd_col(s_cmd_col), .cmd_first(s_cmd_first),
        .cmd_last(s_cmd_last), .busy(s_busy), .finish(s_finish), .err(s_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference walk of the default layer stack, written as plain nested loops.
    function automatic void pushExpected(input logic [47:0] maps);
        int   side;
        int   so;
        int   mi;
        int   mo;
        bit   ok;
        bit   pool;
        cmd_t e;
        side = 32;
        for (int l = 0; l < 5; l++) begin
            pool = DEF_MODE[l];
            mi   = int'(maps[l*8 +: 8]);
            mo   = pool ? mi : int'(maps[(l+1)*8 +: 8]);
            if (pool) begin
                so = side / 2;
                ok = (so > 0);
            end else begin
                ok = (side >= 5);
                so = side - 4;
            end
            if (!ok || mi == 0 || mo == 0) continue;
            if (pool) begin
                for (int m = 0; m < mi; m++)
                    for (int r = 0; r < so; r++)
                        for (int cc = 0; cc < so; cc++) begin
                            e = '{3'(l), 1'b1, 8'(m), 8'(m), 5'(r*2), 5'(cc*2), 1'b1, 1'b1};
                            sb.push_back(e);
                        end
            end else begin
                for (int o = 0; o < mo; o++)
                    for (int i = 0; i < mi; i++)
                        for (int r = 0; r < so; r++)
                            for (int cc = 0; cc < so; cc++) begin
                                e = '{3'(l), 1'b0, 8'(o), 8'(i), 5'(r), 5'(cc), i == 0, i == mi - 1};
                                sb.push_back(e);
                            end
            end
            side = so;
        end
    endfunction

    task automatic applyStimulus(input logic [47:0] maps);
        @(posedge clk);
        #1;
        pushExpected(maps);
        layer_maps = maps;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("setup_busy_novalid", {busy, cmd_valid}, 2'b10);
        @(negedge clk);
        checkOutput("first_valid_t2", cmd_valid, 1'b1);
    endtask

    task automatic waitFinish(input int budget, input string tag);
        int base;
        int n;
        base = finish_cnt;
        n    = 0;
        while (finish_cnt == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, finish_cnt != base, 1'b1);
    endtask

    task automatic waitSmallFinish(input int budget, input string tag);
        int base;
        int n;
        base = s_fin;
        n    = 0;
        while (s_fin == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, s_fin != base, 1'b1);
    endtask

    initial begin
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       cmd_ready = 1'b1;
                1:       cmd_ready = ($urandom_range(3) != 0);
                default: cmd_ready = 1'b0;
            endcase
        end
    end

    initial s_cmd_ready = 1'b1;

    // Main-instance monitor: scoreboard pops, stall stability and finish timing.
    always @(negedge clk) begin
        cmd_t obs;
        cmd_t exp;
        obs = {cmd_layer, cmd_pool, cmd_out_map, cmd_in_map, cmd_row, cmd_col, cmd_first, cmd_last};
        if (rst) begin
            prev_stall = 1'b0;
            expect_fin = 1'b0;
        end else begin
            if (expect_fin) begin
                checkOutput("finish_after_last", finish, 1'b1);
                expect_fin = 1'b0;
            end
            if (finish) begin
                finish_cnt++;
                checkOutput("finish_excl_valid_busy", {cmd_valid, busy}, 2'b00);
            end
            if (prev_stall) begin
                checkOutput("stall_valid_held", cmd_valid, 1'b1);
                checkOutput("stall_fields_held", obs, held);
            end
            if (cmd_valid && cmd_ready) begin
                checkOutput("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    checkOutput("cmd", obs, exp);
                    if (sb.size() == 0) expect_fin = 1'b1;
                end
            end
            prev_stall = cmd_valid && !cmd_ready;
            held       = obs;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (s_cmd_valid && s_cmd_ready) begin
                if (s_hs == 0) begin
                    s_first = {s_cmd_layer, s_cmd_pool, s_cmd_out_map, s_cmd_in_map,
                               s_cmd_row, s_cmd_col, s_cmd_first, s_cmd_last};
                end
                s_hs++;
            end
            if (s_finish) s_fin++;
        end
    end

    initial begin
        int base;
        rst        = 1'b1;
        start      = 1'b0;
        layer_maps = '0;
        s_start    = 1'b0;
        s_maps     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", {cmd_valid, busy, finish, err}, 4'b0000);
        checkOutput("reset_fields",
                    {cmd_layer, cmd_pool, cmd_out_map, cmd_in_map, cmd_row, cmd_col, cmd_first, cmd_last}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] full default run, ready held high");
        applyStimulus(DEF_MAPS);
        waitFinish(20000, "run1_finish");
        @(negedge clk);
        checkOutput("run1_sb_empty", sb.size(), 32'd0);
        checkOutput("run1_err_busy", {err, busy}, 2'b00);

        $display("[TB] full default run, random stalls");
        ready_mode = 1;
        applyStimulus(DEF_MAPS);
        waitFinish(40000, "run2_finish");
        ready_mode = 0;
        @(negedge clk);
        checkOutput("run2_sb_empty", sb.size(), 32'd0);
        checkOutput("run2_err", err, 1'b0);

        $display("[TB] three input maps, zero-map layers skipped");
        applyStimulus({8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd3});
        waitFinish(5000, "run3_finish");
        @(negedge clk);
        checkOutput("run3_sb_empty", sb.size(), 32'd0);
        checkOutput("run3_err", err, 1'b0);

        $display("[TB] start ignored mid-run, then reset abort");
        applyStimulus(DEF_MAPS);
        repeat (50) @(posedge clk);
        #1;
        layer_maps = {8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_abort_valid_busy", {cmd_valid, busy}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        base = finish_cnt;
        repeat (30) @(posedge clk);
        checkOutput("no_finish_after_rst", finish_cnt - base, 32'd0);

        $display("[TB] small stack with invalid final layer");
        base = s_hs;
        @(posedge clk);
        #1;
        s_maps  = {8'd3, 8'd2, 8'd2, 8'd1};
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        waitSmallFinish(500, "small_finish");
        @(negedge clk);
        checkOutput("small_cmd_count", s_hs - base, 32'd40);
        checkOutput("small_first_cmd", s_first, {2'd0, 1'b0, 8'd0, 8'd0, 3'd0, 3'd0, 1'b1, 1'b1});
        checkOutput("small_err_set", {s_err, s_busy}, 2'b10);
        @(posedge clk);
        #1;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        @(negedge clk);
        checkOutput("small_err_cleared", {s_err, s_busy}, 2'b01);
        waitSmallFinish(500, "small_finish2");
        @(negedge clk);
        checkOutput("small_err_again", s_err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
